// File: rtl/sram_fifo_512x64.sv
// rtl/sram_fifo_512x64.sv - stream FIFO controller over a 512x64 dual-port SRAM
// The SRAM writes every cycle, so the wr_ptr slot is kept free (511 usable entries).

module sram_512x64 (
  input  logic        clk,
  input  logic [8:0]  waddr,
  input  logic [63:0] wdata,
  input  logic [8:0]  raddr,
  output logic [63:0] rdata
);
  logic [63:0] r_mem [0:511];

  always_ff @(posedge clk) begin
    r_mem[waddr] <= wdata;
    rdata        <= r_mem[raddr];
  end
endmodule

module sram_fifo_512x64 #(
  parameter int unsigned ALMOST_FULL = 448
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [9:0]  level,
  output logic        almost_full
);
  logic [8:0]  r_wr_ptr;
  logic [8:0]  r_rd_ptr;
  logic [8:0]  r_mem_cnt;
  logic        r_rd_pend;
  logic [1:0]  r_ob_cnt;
  logic [63:0] r_ob0;
  logic [63:0] r_ob1;

  logic        w_push;
  logic        w_pop;
  logic        w_issue;
  logic [2:0]  w_ob_occ;
  logic [1:0]  w_ob_after_pop;
  logic [63:0] w_rdata;

  sram_512x64 u_sram (
    .clk   (clk),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  assign in_ready       = rst_n && (r_mem_cnt != 9'd511);
  assign out_valid      = (r_ob_cnt != 2'd0);
  assign out_data       = r_ob0;
  assign w_push         = in_valid && in_ready;
  assign w_pop          = out_valid && out_ready;
  // Buffer slots committed after this cycle's pop, including the read in flight.
  assign w_ob_occ       = {1'b0, r_ob_cnt} + {2'b0, r_rd_pend} - {2'b0, w_pop};
  assign w_issue        = (r_mem_cnt != 9'd0) && (w_ob_occ < 3'd2);
  assign w_ob_after_pop = r_ob_cnt - {1'b0, w_pop};

  assign level       = {1'b0, r_mem_cnt} + {9'b0, r_rd_pend} + {8'b0, r_ob_cnt};
  assign almost_full = (level >= 10'(ALMOST_FULL));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 9'd1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 9'd1;
      r_mem_cnt <= r_mem_cnt + {8'b0, w_push} - {8'b0, w_issue};
      r_rd_pend <= w_issue;
    end
  end

  // Pop shifts the head; a same-cycle capture lands in the slot freed behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ob_cnt <= '0;
      r_ob0    <= '0;
      r_ob1    <= '0;
    end else begin
      if (w_pop) r_ob0 <= r_ob1;
      if (r_rd_pend) begin
        if (w_ob_after_pop == 2'd0) r_ob0 <= w_rdata;
        else                        r_ob1 <= w_rdata;
      end
      r_ob_cnt <= w_ob_after_pop + {1'b0, r_rd_pend};
    end
  end
endmodule

// File: tb/tb_sram_fifo_512x64.sv
// tb/tb_sram_fifo_512x64.sv - self-checking bench for sram_fifo_512x64

module tb_sram_fifo_512x64;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [9:0]  level;
  logic        almost_full;

  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  logic [63:0] seq_data = 64'h5A00_0000_0000_0000;

  sram_fifo_512x64 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        e_ov;
    logic [63:0] e_od;
    logic [9:0]  e_lvl;
    logic        e_irdy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs already applied; scoreboard the handshake at the next edge, then check level.
  task automatic step();
    logic push;
    logic pop;
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
    if (pop) begin
      if (q.size() == 0) chk("pop_on_empty_model", 64'd1, 64'd0);
      else begin
        chk("pop_data", out_data, q[0]);
        void'(q.pop_front());
      end
    end
    if (push) q.push_back(in_data);
    @(posedge clk);
    @(negedge clk);
    chk("level", 64'(level), 64'(q.size()));
    chk("almost_full", 64'(almost_full), 64'(q.size() >= 448));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int acc, pops, bubbles, maxl, cyc;
    bit seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_almost_full", 64'(almost_full), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    //           iv    id                     ordy  e_ov  e_od                   lvl    irdy
    vecs[0] = '{1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b0, 64'h0,               10'd1, 1'b1};
    vecs[1] = '{1'b0, 64'h0,               1'b1, 1'b0, 64'h0,               10'd1, 1'b1};
    vecs[2] = '{1'b0, 64'h0,               1'b1, 1'b1, 64'h0123456789ABCDEF, 10'd1, 1'b1};
    vecs[3] = '{1'b0, 64'h0,               1'b1, 1'b0, 64'h0,               10'd0, 1'b1};
    vecs[4] = '{1'b1, 64'hAAAA0000AAAA0000, 1'b0, 1'b0, 64'h0,               10'd1, 1'b1};
    vecs[5] = '{1'b1, 64'hBBBB1111BBBB1111, 1'b0, 1'b0, 64'h0,               10'd2, 1'b1};
    vecs[6] = '{1'b0, 64'h0,               1'b0, 1'b1, 64'hAAAA0000AAAA0000, 10'd2, 1'b1};
    vecs[7] = '{1'b0, 64'h0,               1'b0, 1'b1, 64'hAAAA0000AAAA0000, 10'd2, 1'b1};
    vecs[8] = '{1'b0, 64'h0,               1'b1, 1'b1, 64'hBBBB1111BBBB1111, 10'd1, 1'b1};
    vecs[9] = '{1'b0, 64'h0,               1'b1, 1'b0, 64'h0,               10'd0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
      chk($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].e_lvl));
      chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_irdy));
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Streaming with pointer wrap
    do_reset();
    acc = 0; pops = 0; bubbles = 0; maxl = 0; seen = 0;
    for (cyc = 0; cyc < 2100 && pops < 2000; cyc++) begin
      in_valid = (acc < 2000); in_data = 64'(acc) | 64'hC0DE_0000_0000_0000; out_ready = 1'b1;
      #1;
      if (in_valid && in_ready) acc++;
      if (seen && !out_valid) bubbles++;
      if (out_valid) begin
        seen = 1;
        pops++;
      end
      if (seen && int'(level) > maxl) maxl = int'(level);
      step();
    end
    chk("stream_popped", 64'(pops), 64'd2000);
    chk("stream_bubbles", 64'(bubbles), 64'd0);
    chk("stream_level_le3", 64'(maxl <= 3), 64'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Fill with the consumer stalled
    do_reset();
    acc = 0;
    for (int i = 0; i < 530; i++) begin
      in_valid = 1'b1; in_data = seq_data; out_ready = 1'b0;
      #1;
      if (in_ready) begin
        acc++;
        seq_data++;
      end
      step();
    end
    chk("fill_accepted", 64'(acc), 64'd513);
    chk("fill_level", 64'(level), 64'd513);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_almost_full", 64'(almost_full), 64'd1);

    // Drain from full
    in_valid = 1'b0; out_ready = 1'b1;
    for (cyc = 0; cyc < 600 && q.size() > 0; cyc++) step();
    chk("drain_empty_model", 64'(q.size()), 64'd0);
    step();
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_level", 64'(level), 64'd0);

    // Random stalls
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom};
      #1;
      step();
    end

    // Mid-stream reset at level 200
    do_reset();
    for (cyc = 0; cyc < 400 && q.size() < 200; cyc++) begin
      in_valid = 1'b1; in_data = seq_data; out_ready = 1'b0;
      seq_data++;
      #1;
      step();
    end
    in_valid = 1'b0;
    chk("pre_reset_level", 64'(level), 64'd200);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 64'hFEED_FACE_DEAD_BEEF; out_ready = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    for (cyc = 0; cyc < 10 && !out_valid; cyc++) step();
    chk("midrst_next_valid", 64'(out_valid), 64'd1);
    chk("midrst_next_data", out_data, 64'hFEED_FACE_DEAD_BEEF);
    step();
    chk("midrst_after_pop_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
